m68k_bus_responder: RTL and testbench

- Synchronous 32-bit-port slave for the 68020 asynchronous bus; the responder end of the cycles run by the 68020 bus interface.
- Decodes an address window, inserts programmable wait states, returns longword read data, applies byte-lane writes to an internal memory, and terminates each cycle with nDSACK=00 (32-bit port).
- Sits beside the CPU bus model as ROM/RAM and replaces ad-hoc testbench response logic.

---
 rtl/m68k_bus_if.sv | 31 +++
 rtl/m68k_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_if.sv
// 68020 asynchronous bus as seen by one 32-bit responder.
// D is resolved here from the master and slave drive/enable pairs.
interface m68k_bus_if;
  logic [31:0] A;
  logic [1:0]  SIZ;
  logic        RnW;
  logic        nAS;
  logic        nDS;
  logic [1:0]  nDSACK;
  logic        nBERR;
  logic        sel;

  logic [31:0] s_d;
  logic        s_oe;
  logic [31:0] m_d;
  logic        m_oe;
  wire  [31:0] D;

  assign D = s_oe ? s_d : 32'bz;
  assign D = m_oe ? m_d : 32'bz;

  modport slave (
    input  A, SIZ, RnW, nAS, nDS, D,
    output nDSACK, nBERR, sel, s_d, s_oe
  );

  modport master (
    output A, SIZ, RnW, nAS, nDS, m_d, m_oe,
    input  D, nDSACK, nBERR, sel, s_oe
  );
endinterface

// File: rtl/m68k_bus_responder.sv
// 32-bit-port memory slave for the 68020 asynchronous bus: window decode,
// programmable wait states, longword reads, byte-lane writes, nDSACK=00 termination.
module m68k_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2,
  parameter bit          READ_ONLY   = 1'b0,
  parameter string       MEM_INIT    = ""
) (
  input  logic        CLK,
  input  logic        nRESET,
  m68k_bus_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, DECODE, WAIT, ACK, HOLD} state_t;

  state_t                 state;
  logic                   as_meta, as_s;
  logic                   ds_meta, ds_s;
  logic [31:0]            a_q;
  logic [1:0]             siz_q;
  logic                   rnw_q;
  logic [3:0]             cnt;
  logic                   data_phase;
  logic [1:0]             ndsack_q;
  logic                   nberr_q;
  logic                   sel_q;
  logic                   d_oe_q;
  logic [31:0]            d_q;

  logic [31:0]            offset;
  logic                   hit;
  logic [ADDR_BITS-1:0]   index;
  logic [3:0]             be;
  logic                   mem_we;

  logic [31:0] mem [0:(1<<ADDR_BITS)-1];

  // Lane mask, bit 3 = lane 0 (D31:24). The port spans from A[1:0] to the
  // end of the longword, clipped to the operand size.
  function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] off);
    case (siz)
      2'b01:   lane_mask = 4'b1000 >> off;
      2'b10:   lane_mask = 4'b1100 >> off;
      2'b11:   lane_mask = 4'b1110 >> off;
      default: lane_mask = 4'b1111 >> off;
    endcase
  endfunction

  assign offset = a_q - BASE_ADDR;
  assign hit    = offset < (32'd4 << ADDR_BITS);
  assign index  = offset[ADDR_BITS+1:2];
  assign be     = lane_mask(siz_q, a_q[1:0]);
  assign mem_we = (state == ACK) && !rnw_q && !READ_ONLY;

  // NOTE: the memory array has no reset branch; contents survive nRESET and
  // it maps onto plain RAM rather than thousands of resettable flops.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[index][8*k +: 8] <= bus.D[8*k +: 8];
      end
    end
  end

  // NOTE: every state element here uses <= so all flops update from the
  // same pre-edge values, including the two-stage synchronizers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      as_meta    <= 1'b1;
      as_s       <= 1'b1;
      ds_meta    <= 1'b1;
      ds_s       <= 1'b1;
      state      <= IDLE;
      a_q        <= '0;
      siz_q      <= '0;
      rnw_q      <= 1'b1;
      cnt        <= '0;
      data_phase <= 1'b0;
      ndsack_q   <= 2'b11;
      nberr_q    <= 1'b1;
      sel_q      <= 1'b0;
      d_oe_q     <= 1'b0;
      d_q        <= '0;
    end else begin
      as_meta <= bus.nAS;
      as_s    <= as_meta;
      ds_meta <= bus.nDS;
      ds_s    <= ds_meta;

      case (state)
        IDLE: begin
          if (!as_s) begin
            a_q   <= bus.A;
            siz_q <= bus.SIZ;
            rnw_q <= bus.RnW;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (as_s) begin
            state <= HOLD;
          end else if (hit) begin
            sel_q <= 1'b1;
            cnt   <= 4'(WAIT_STATES);
            state <= WAIT;
          end else begin
            state <= HOLD;
          end
        end
        WAIT: begin
          if (as_s) begin
            state <= HOLD;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!ds_s) begin
            data_phase <= 1'b0;
            state      <= ACK;
          end
        end
        ACK: begin
          // Reads put data on D one cycle ahead of nDSACK.
          if (rnw_q) begin
            if (!data_phase) begin
              d_q        <= mem[index];
              d_oe_q     <= 1'b1;
              data_phase <= 1'b1;
            end else begin
              ndsack_q <= 2'b00;
              state    <= HOLD;
            end
          end else if (READ_ONLY) begin
            nberr_q <= 1'b0;
            state   <= HOLD;
          end else begin
            ndsack_q <= 2'b00;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (as_s) begin
            ndsack_q <= 2'b11;
            nberr_q  <= 1'b1;
            d_oe_q   <= 1'b0;
            sel_q    <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.nDSACK = ndsack_q;
  assign bus.nBERR  = nberr_q;
  assign bus.sel    = sel_q;
  assign bus.s_d    = d_q;
  assign bus.s_oe   = d_oe_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: three instances (normal, read-only,
// long wait) driven by one bus master, read data checked against a scoreboard.
module tb_m68k_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  tgt;
  logic        nas, nds, rnw, moe;
  logic [31:0] a, md;
  logic [1:0]  siz;

  m68k_bus_if b0 ();
  m68k_bus_if b1 ();
  m68k_bus_if b2 ();

  assign b0.A = a;  assign b0.SIZ = siz;  assign b0.RnW = rnw;  assign b0.nDS = nds;
  assign b1.A = a;  assign b1.SIZ = siz;  assign b1.RnW = rnw;  assign b1.nDS = nds;
  assign b2.A = a;  assign b2.SIZ = siz;  assign b2.RnW = rnw;  assign b2.nDS = nds;
  assign b0.m_d = md;  assign b0.m_oe = moe && (tgt == 2'd0);
  assign b1.m_d = md;  assign b1.m_oe = moe && (tgt == 2'd1);
  assign b2.m_d = md;  assign b2.m_oe = moe && (tgt == 2'd2);
  assign b0.nAS = (tgt == 2'd0) ? nas : 1'b1;
  assign b1.nAS = (tgt == 2'd1) ? nas : 1'b1;
  assign b2.nAS = (tgt == 2'd2) ? nas : 1'b1;

  m68k_bus_responder #(.WAIT_STATES(2)) dut (
    .CLK(clk), .nRESET(rst_n), .bus(b0.slave));
  m68k_bus_responder #(.WAIT_STATES(0), .READ_ONLY(1'b1)) dut_ro (
    .CLK(clk), .nRESET(rst_n), .bus(b1.slave));
  m68k_bus_responder #(.WAIT_STATES(4)) dut_ab (
    .CLK(clk), .nRESET(rst_n), .bus(b2.slave));

  // Observed outputs of the currently addressed instance.
  logic [1:0]  o_ndsack;
  logic        o_nberr, o_sel, o_soe;
  logic [31:0] o_d;
  always_comb begin
    o_ndsack = b0.nDSACK;  o_nberr = b0.nBERR;  o_sel = b0.sel;  o_soe = b0.s_oe;  o_d = b0.D;
    if (tgt == 2'd1) begin
      o_ndsack = b1.nDSACK;  o_nberr = b1.nBERR;  o_sel = b1.sel;  o_soe = b1.s_oe;  o_d = b1.D;
    end else if (tgt == 2'd2) begin
      o_ndsack = b2.nDSACK;  o_nberr = b2.nBERR;  o_sel = b2.sel;  o_soe = b2.s_oe;  o_d = b2.D;
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [0:7];

  int          lat, rel;
  logic [1:0]  t_dsack;
  logic        t_berr, t_sel, oe_before;
  logic [31:0] t_d, v0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete bus cycle. exp_term = {nDSACK, nBERR} at termination.
  task automatic bus_cycle(input logic r, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [31:0] wd, input logic [2:0] exp_term, input bit use_scb);
    logic prev_oe;
    logic done;
    logic [31:0] e;
    @(negedge clk);
    a = addr;  siz = sz;  rnw = r;  md = wd;  moe = ~r;  nas = 1'b0;  nds = 1'b0;
    lat = 0;  done = 1'b0;  prev_oe = 1'b0;
    while (!done && lat < 60) begin
      prev_oe = o_soe;
      @(negedge clk);
      lat++;
      if (o_ndsack != 2'b11 || o_nberr == 1'b0) done = 1'b1;
    end
    oe_before = prev_oe;  t_dsack = o_ndsack;  t_berr = o_nberr;  t_d = o_d;  t_sel = o_sel;
    check("termination", {29'd0, t_dsack, t_berr}, {29'd0, exp_term});
    nas = 1'b1;  nds = 1'b1;  moe = 1'b0;
    rel = 0;
    while (rel < 10 && !(o_ndsack == 2'b11 && o_nberr && !o_soe && !o_sel)) begin
      @(negedge clk);
      rel++;
    end
    check("release_within_3", 32'(rel <= 3), 32'd1);
    if (r && use_scb) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check("read_data", t_d, e);
    end
  endtask

  // Bench-side lane rule: bytes from A[1:0] up to the longword end, at most size bytes.
  task automatic wr(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
    int n;
    int off;
    n   = (sz == 2'b00) ? 4 : int'(sz);
    off = int'(addr[1:0]);
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + n) model[addr[4:2]][31-8*k -: 8] = data[31-8*k -: 8];
    bus_cycle(1'b0, addr, sz, data, 3'b001, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr);
    exp_q.push_back(model[addr[4:2]]);
    bus_cycle(1'b1, addr, 2'b00, 32'd0, 3'b001, 1'b1);
  endtask

  initial begin
    tgt = 2'd0;  nas = 1'b1;  nds = 1'b1;  rnw = 1'b1;  moe = 1'b0;
    a = '0;  md = '0;  siz = 2'b00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ndsack", {30'd0, b0.nDSACK}, 32'd3);
    check("reset_nberr",  {31'd0, b0.nBERR},  32'd1);
    check("reset_sel",    {31'd0, b0.sel},    32'd0);
    check("reset_d_oe",   {31'd0, b0.s_oe},   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill mem[0..7] of the normal instance.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      v = (i == 1) ? 32'h0 : (i == 3) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i * 32'h111));
      wr(32'(i * 4), 2'b00, v);
    end

    // Read hit: 2 sync + capture + decode + 2 waits + wait exit + data + ack = 9.
    rd(32'h0000_000C);
    check("read_latency", 32'(lat), 32'd9);
    check("data_before_dsack", {31'd0, oe_before}, 32'd1);
    check("sel_at_ack", {31'd0, t_sel}, 32'd1);

    // Byte-lane writes into mem[1].
    wr(32'h5, 2'b01, 32'h0011_0000);
    wr(32'h6, 2'b10, 32'h0000_2233);
    wr(32'h4, 2'b01, 32'h4400_0000);
    rd(32'h4);
    wr(32'h9,  2'b11, 32'h00AA_BBCC);
    wr(32'h12, 2'b00, 32'h1234_7788);
    rd(32'h8);
    rd(32'h10);

    // Miss: one past the end of the 4 KiB window.
    @(negedge clk);
    a = 32'h0000_1000;  rnw = 1'b1;  siz = 2'b00;  nas = 1'b0;  nds = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("miss_quiet", {28'd0, o_ndsack, o_sel, o_soe}, {28'd0, 4'b1100});
    end
    nas = 1'b1;  nds = 1'b1;
    repeat (4) @(negedge clk);

    // Read-only instance: write ends in bus error, memory unchanged.
    tgt = 2'd1;
    bus_cycle(1'b1, 32'h0, 2'b00, 32'd0, 3'b001, 1'b0);
    v0 = t_d;
    bus_cycle(1'b0, 32'h0, 2'b00, 32'h1234_5678, 3'b110, 1'b0);
    exp_q.push_back(v0);
    bus_cycle(1'b1, 32'h0, 2'b00, 32'd0, 3'b001, 1'b1);

    // Abort on the 4-wait instance: nAS held for one clock only.
    tgt = 2'd2;
    bus_cycle(1'b0, 32'h8, 2'b00, 32'h0BAD_F00D, 3'b001, 1'b0);
    @(negedge clk);
    a = 32'h8;  rnw = 1'b1;  siz = 2'b00;  nas = 1'b0;  nds = 1'b0;
    @(negedge clk);
    nas = 1'b1;  nds = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("abort_quiet", {29'd0, o_ndsack, o_soe}, {29'd0, 3'b110});
    end
    exp_q.push_back(32'h0BAD_F00D);
    bus_cycle(1'b1, 32'h8, 2'b00, 32'd0, 3'b001, 1'b1);

    // Async reset while a read sits in ACK with data already driven.
    tgt = 2'd0;
    @(negedge clk);
    a = 32'h14;  rnw = 1'b1;  siz = 2'b00;  nas = 1'b0;  nds = 1'b0;
    begin
      int w;
      w = 0;
      while (!o_soe && w < 40) begin
        @(negedge clk);
        w++;
      end
    end
    check("reached_ack", {31'd0, o_soe}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_ack", {29'd0, o_ndsack, o_soe}, {29'd0, 3'b110});
    nas = 1'b1;  nds = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) rd(32'(i * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
